// File: rtl/key_step_ctrl.sv
// rtl/key_step_ctrl.sv - DE2 key/switch front end producing step, reset and auto-run events
//
// Turns raw active-low push buttons and slide switches into clean single-cycle
// control events for a processor clocked from clk that advances on step_pulse.
//
// Ports:
//   clk         system clock (CLOCK_50)
//   reset       synchronous active-high block reset
//   keys_n[3:0] raw KEY inputs, active-low, asynchronous (3 = step, 0 = cpu reset)
//   run_en      raw switch, 1 selects auto-run stepping
//   rate[1:0]   raw switches, auto period = AUTO_BASE << rate
//   key_down    debounced key levels, 1 = pressed
//   step_pulse  one-cycle processor step enable
//   cpu_reset   processor reset, active-high, stretched after release
//   step_count  steps issued since the last cpu_reset
module key_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int AUTO_BASE       = 12500000,
    parameter int RST_STRETCH     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  keys_n,
    input  logic        run_en,
    input  logic [1:0]  rate,
    output logic [3:0]  key_down,
    output logic        step_pulse,
    output logic        cpu_reset,
    output logic [15:0] step_count
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int TW = $clog2(AUTO_BASE) + 3;
    localparam int SW = $clog2(RST_STRETCH + 1);

    // Synchronizers plus one registered sample stage feeding the debouncers.
    logic [3:0] key_s1, key_s2, key_smp;
    logic       run_s1, run_s2;
    logic [1:0] rate_s1, rate_s2;

    // Debounce state
    logic [3:0]    deb, deb_next;
    logic [CW-1:0] deb_cnt  [4];
    logic [CW-1:0] cnt_next [4];
    logic [3:0]    pressed;
    logic          deb3_d;

    // Reset stretch
    logic [SW-1:0] stretch, stretch_next;
    logic          cpu_next;

    // Auto-run timer
    logic [TW-1:0] timer, timer_next;
    logic [TW:0]   period_m1;
    logic          tick;
    logic          manual;
    logic          step_next;

    assign pressed  = ~key_smp;
    assign key_down = deb;

    always_comb begin
        deb_next = deb;
        for (int i = 0; i < 4; i++) begin
            cnt_next[i] = '0;
            if (pressed[i] != deb[i]) begin
                if (deb_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_next[i] = ~deb[i];
                end else begin
                    cnt_next[i] = deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // cpu_reset follows the next-state debounced KEY[0] so it rises on the
    // same edge as key_down[0]; the stretch counter counts up to RST_STRETCH
    // after the hold condition drops.
    always_comb begin
        stretch_next = stretch;
        cpu_next     = 1'b0;
        if (reset || deb_next[0]) begin
            stretch_next = '0;
            cpu_next     = 1'b1;
        end else if (stretch != SW'(RST_STRETCH)) begin
            stretch_next = stretch + 1'b1;
            cpu_next     = 1'b1;
        end
    end

    assign period_m1 = ((TW+1)'(AUTO_BASE) << rate_s2) - (TW+1)'(1);

    // A rate change is detected one stage early (s1 vs s2) so the timer
    // restarts from 0 on the same edge the synchronized rate changes.
    always_comb begin
        timer_next = timer;
        tick       = 1'b0;
        if (!run_s2 || cpu_reset || (rate_s1 != rate_s2)) begin
            timer_next = '0;
        end else if ({1'b0, timer} == period_m1) begin
            timer_next = '0;
            tick       = 1'b1;
        end else begin
            timer_next = timer + 1'b1;
        end
    end

    assign manual    = deb[3] & ~deb3_d & ~run_s2;
    assign step_next = (manual | tick) & ~cpu_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_s1     <= 4'hF;
            key_s2     <= 4'hF;
            key_smp    <= 4'hF;
            run_s1     <= 1'b0;
            run_s2     <= 1'b0;
            rate_s1    <= 2'b00;
            rate_s2    <= 2'b00;
            deb        <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt[i] <= '0;
            end
            deb3_d     <= 1'b0;
            stretch    <= '0;
            cpu_reset  <= 1'b1;
            timer      <= '0;
            step_pulse <= 1'b0;
            step_count <= 16'h0000;
        end else begin
            key_s1     <= keys_n;
            key_s2     <= key_s1;
            key_smp    <= key_s2;
            run_s1     <= run_en;
            run_s2     <= run_s1;
            rate_s1    <= rate;
            rate_s2    <= rate_s1;
            deb        <= deb_next;
            for (int i = 0; i < 4; i++) begin
                deb_cnt[i] <= cnt_next[i];
            end
            deb3_d     <= deb[3];
            stretch    <= stretch_next;
            cpu_reset  <= cpu_next;
            timer      <= timer_next;
            step_pulse <= step_next;
            if (cpu_next) begin
                step_count <= 16'h0000;
            end else begin
                step_count <= step_count + {15'd0, step_pulse};
            end
        end
    end

endmodule

// File: tb/tb_key_step_ctrl.sv
// tb/tb_key_step_ctrl.sv - self-checking bench for key_step_ctrl
module tb_key_step_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  keys_n;
    logic        run_en;
    logic [1:0]  rate;
    logic [3:0]  key_down;
    logic        step_pulse;
    logic        cpu_reset;
    logic [15:0] step_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    key_step_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .AUTO_BASE      (8),
        .RST_STRETCH    (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .keys_n    (keys_n),
        .run_en    (run_en),
        .rate      (rate),
        .key_down  (key_down),
        .step_pulse(step_pulse),
        .cpu_reset (cpu_reset),
        .step_count(step_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        rst;
        logic [3:0]  kn;
        logic        cpu;
        logic [3:0]  kd;
        logic        sp;
        logic [15:0] sc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input logic rst, input logic [3:0] kn, input logic cpu,
                       input logic [3:0] kd, input logic sp, input logic [15:0] sc);
        vec_t v;
        v.rst = rst; v.kn = kn; v.cpu = cpu; v.kd = kd; v.sp = sp; v.sc = sc;
        repeat (n) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic wait_pulse(input int max, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (step_pulse === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s actual=no_pulse expected=pulse within %0d cycles", name, max);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tp;
        reset  = 1'b1;
        keys_n = 4'hF;
        run_en = 1'b0;
        rate   = 2'b00;

        // Power-up, clean KEY[3] press (edge t = row 6) and release.
        add(2,  1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 16'd0);
        add(3,  1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 16'd0);
        add(1,  1'b0, 4'hF, 1'b0, 4'h0, 1'b0, 16'd0);
        add(6,  1'b0, 4'h7, 1'b0, 4'h0, 1'b0, 16'd0);
        add(1,  1'b0, 4'h7, 1'b0, 4'h8, 1'b0, 16'd0);
        add(1,  1'b0, 4'h7, 1'b0, 4'h8, 1'b1, 16'd0);
        add(12, 1'b0, 4'h7, 1'b0, 4'h8, 1'b0, 16'd1);
        add(6,  1'b0, 4'hF, 1'b0, 4'h8, 1'b0, 16'd1);
        add(3,  1'b0, 4'hF, 1'b0, 4'h0, 1'b0, 16'd1);

        foreach (vecs[i]) begin
            reset  = vecs[i].rst;
            keys_n = vecs[i].kn;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_cpu_reset", i), 32'(cpu_reset), 32'(vecs[i].cpu));
            check($sformatf("vec%0d_key_down", i), 32'(key_down), 32'(vecs[i].kd));
            check($sformatf("vec%0d_step_pulse", i), 32'(step_pulse), 32'(vecs[i].sp));
            check($sformatf("vec%0d_step_count", i), 32'(step_count), 32'(vecs[i].sc));
        end

        // Mid-operation block reset clears the count on the next edge.
        reset = 1'b1;
        @(negedge clk);
        check("midreset_count", 32'(step_count), 32'd0);
        check("midreset_cpu", 32'(cpu_reset), 32'd1);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("midreset_cpu_released", 32'(cpu_reset), 32'd0);

        // Bounce: toggle every cycle, never accepted.
        for (int i = 0; i < 20; i++) begin
            keys_n = (i < 10 && (i % 2) == 0) ? 4'h7 : 4'hF;
            @(negedge clk);
            check($sformatf("bounce%0d_key_down", i), 32'(key_down), 32'd0);
            check($sformatf("bounce%0d_step", i), 32'(step_pulse), 32'd0);
        end
        check("bounce_count", 32'(step_count), 32'd0);

        // Auto-run at rate 1: 16-cycle spacing, manual press ignored.
        run_en = 1'b1;
        rate   = 2'b01;
        wait_pulse(100, "auto_first");
        tp = cyc;
        keys_n = 4'h7;
        for (int k = 2; k <= 5; k++) begin
            wait_pulse(40, $sformatf("auto_pulse%0d", k));
            check($sformatf("auto_interval%0d", k), 32'(cyc - tp), 32'd16);
            tp = cyc;
            if (k == 2) begin
                check("auto_key3_down", 32'(key_down[3]), 32'd1);
                keys_n = 4'hF;
            end
        end
        rate = 2'b00;
        @(negedge clk);
        check("auto_count5", 32'(step_count), 32'd5);
        wait_pulse(40, "rate_change_pulse");
        check("rate_change_interval", 32'(cyc - tp), 32'd10);
        tp = cyc;
        wait_pulse(40, "rate0_pulse");
        check("rate0_interval", 32'(cyc - tp), 32'd8);

        // KEY[0] press timed so cpu_reset rises on a due tick (edge p+8).
        wait_pulse(40, "pre_reset_pulse");
        @(negedge clk);
        keys_n = 4'hE;
        for (int k = 2; k <= 30; k++) begin
            @(negedge clk);
            check($sformatf("rst_k%0d_cpu", k), 32'(cpu_reset), 32'(k >= 8 && k <= 20));
            check($sformatf("rst_k%0d_key0", k), 32'(key_down[0]), 32'(k >= 8 && k <= 17));
            check($sformatf("rst_k%0d_step", k), 32'(step_pulse), 32'(k == 29));
            if (k >= 8 && k <= 29) begin
                check($sformatf("rst_k%0d_count", k), 32'(step_count), 32'd0);
            end
            if (k == 11) begin
                keys_n = 4'hF;
            end
        end
        check("rst_resume_count", 32'(step_count), 32'd1);

        // Wrap: preload the counter, next auto step wraps it to zero.
        @(negedge clk);
        force dut.step_count = 16'hFFFF;
        #1;
        release dut.step_count;
        wait_pulse(20, "wrap_pulse");
        @(negedge clk);
        check("wrap_count", 32'(step_count), 32'd0);
        wait_pulse(20, "post_wrap_pulse");
        @(negedge clk);
        check("post_wrap_count", 32'(step_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
